seg_scan_driver: RTL and testbench

Time-multiplexed three-digit seven-segment scan driver that sits directly downstream of the binary-to-BCD seven-segment decoder. It accepts the hundreds, tens and ones segment codes on a load strobe and buffers them so a display never shows a mixed update. It drives one shared active-low segment bus plus three active-low digit enables, with dead time between digits and optional leading-zero blanking. It also emits a one-cycle pulse at each frame boundary.

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_dwell_timer.sv | 61 ++++++
 rtl/seg_scan_driver.sv | 126 ++++++++++++
 tb/tb_seg_scan_driver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the three-digit seven-segment
//               scan driver. Segment codes are active-low, bit6 = a ... bit0 = g.
// Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    typedef logic [6:0] seg_t;

    // All segments off (active-low bus).
    localparam seg_t SEG_BLANK = 7'h7F;
    // Code for the digit "0": every segment lit except g.
    localparam seg_t SEG_ZERO  = 7'b0000001;

    typedef enum logic [1:0] {
        DIG_HUND = 2'd0,
        DIG_TEN  = 2'd1,
        DIG_ONE  = 2'd2
    } dig_idx_t;

    // One-cold digit enable for a slot: [2] = hundreds, [1] = tens, [0] = ones.
    function automatic logic [2:0] dig_enable(input dig_idx_t d);
        logic [2:0] v;
        v = 3'b111;
        case (d)
            DIG_HUND: v = 3'b011;
            DIG_TEN:  v = 3'b101;
            DIG_ONE:  v = 3'b110;
            default:  v = 3'b111;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg_dwell_timer
// Description : Slot timer for the scan driver. A cycle counter runs through
//               0..DWELL-1 per digit slot; the slot index steps
//               hundreds -> tens -> ones -> hundreds at the end of each slot.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               slotActive      - high once the dead time of the slot is over
//               idx             - current digit slot
//               frameEdge       - high in the last cycle of the ones slot
// Revision    : 1.0  initial release
// ============================================================================
module seg_dwell_timer
    import seg_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int DEAD  = 1000
) (
    input  logic     clk,
    input  logic     reset,
    output logic     slotActive,
    output dig_idx_t idx,
    output logic     frameEdge
);

    localparam int              c_CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DWELL - 1);

    logic [c_CW-1:0] r_cnt;
    dig_idx_t        r_idx;
    logic            w_slot_end;

    assign w_slot_end = (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= DIG_HUND;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == DIG_ONE) ? DIG_HUND : dig_idx_t'(r_idx + 2'd1);
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // With no dead time the comparison would be constant-true, so it is
    // elaborated away instead of left as an always-true compare.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign slotActive = 1'b1;
        end else begin : g_dead
            assign slotActive = (r_cnt >= c_CW'(DEAD));
        end
    endgenerate

    assign idx       = r_idx;
    assign frameEdge = w_slot_end && (r_idx == DIG_ONE);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed three-digit seven-segment scan driver.
//               New codes are captured on load into a pending buffer and only
//               moved to the display buffer at a frame boundary, so a frame is
//               never a mix of old and new digits. Optional leading-zero
//               blanking; dead time at the start of each slot.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               load                  - capture hundIn/tenIn/oneIn
//               hundIn, tenIn, oneIn  - active-low segment codes
//               blankEn               - leading-zero blanking enable (live)
//               segOut                - shared segment bus, active-low
//               digitEn               - digit enables, active-low, [2]=hund
//               frameDone             - one-cycle pulse after each frame
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int DEAD  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] hundIn,
    input  logic [6:0] tenIn,
    input  logic [6:0] oneIn,
    input  logic       blankEn,
    output logic [6:0] segOut,
    output logic [2:0] digitEn,
    output logic       frameDone
);

    logic     w_slot_active;
    dig_idx_t w_idx;
    logic     w_frame_edge;

    seg_dwell_timer #(
        .DWELL (DWELL),
        .DEAD  (DEAD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .slotActive (w_slot_active),
        .idx        (w_idx),
        .frameEdge  (w_frame_edge)
    );

    seg_t       r_pend_h, r_pend_t, r_pend_o;
    logic       r_pend_valid;
    seg_t       r_disp_h, r_disp_t, r_disp_o;
    seg_t       r_seg;
    logic [2:0] r_dig;
    logic       r_frame_done;

    // Tens is only a "leading" zero when hundreds is also blanked.
    logic w_blank_h;
    logic w_blank_t;
    seg_t w_seg_sel;

    assign w_blank_h = blankEn && (r_disp_h == SEG_ZERO);
    assign w_blank_t = w_blank_h && (r_disp_t == SEG_ZERO);

    always_comb begin
        w_seg_sel = SEG_BLANK;
        case (w_idx)
            DIG_HUND: w_seg_sel = w_blank_h ? SEG_BLANK : r_disp_h;
            DIG_TEN:  w_seg_sel = w_blank_t ? SEG_BLANK : r_disp_t;
            DIG_ONE:  w_seg_sel = r_disp_o;
            default:  w_seg_sel = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_h     <= SEG_BLANK;
            r_pend_t     <= SEG_BLANK;
            r_pend_o     <= SEG_BLANK;
            r_pend_valid <= 1'b0;
            r_disp_h     <= SEG_BLANK;
            r_disp_t     <= SEG_BLANK;
            r_disp_o     <= SEG_BLANK;
            r_seg        <= SEG_BLANK;
            r_dig        <= 3'b111;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_edge;

            if (w_frame_edge) begin
                // A load landing exactly on the boundary bypasses the pending
                // buffer and is shown in the very next frame.
                if (load) begin
                    r_disp_h <= hundIn;
                    r_disp_t <= tenIn;
                    r_disp_o <= oneIn;
                end else if (r_pend_valid) begin
                    r_disp_h <= r_pend_h;
                    r_disp_t <= r_pend_t;
                    r_disp_o <= r_pend_o;
                end
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_h     <= hundIn;
                r_pend_t     <= tenIn;
                r_pend_o     <= oneIn;
                r_pend_valid <= 1'b1;
            end

            if (!w_slot_active) begin
                r_seg <= SEG_BLANK;
                r_dig <= 3'b111;
            end else begin
                r_seg <= w_seg_sel;
                r_dig <= dig_enable(w_idx);
            end
        end
    end

    assign segOut    = r_seg;
    assign digitEn   = r_dig;
    assign frameDone = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Directed self-checking bench for seg_scan_driver with
//               DWELL = 8, DEAD = 2. Every cycle of each frame is compared
//               against hand-written expected codes for that frame.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int c_DWELL = 8;
    localparam int c_DEAD  = 2;
    localparam int c_FRAME = 3 * c_DWELL;

    localparam logic [6:0] c_B = 7'h7F;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [6:0] hundIn, tenIn, oneIn;
    logic       blankEn;
    logic [6:0] segOut;
    logic [2:0] digitEn;
    logic       frameDone;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_driver #(
        .DWELL (c_DWELL),
        .DEAD  (c_DEAD)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .hundIn    (hundIn),
        .tenIn     (tenIn),
        .oneIn     (oneIn),
        .blankEn   (blankEn),
        .segOut    (segOut),
        .digitEn   (digitEn),
        .frameDone (frameDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of a frame. j is the frame position (0..23) of the cycle in
    // which inputs are driven; outputs are checked #1 after the edge.
    task automatic step(input int j, input logic [20:0] exp_codes,
                        input logic ld, input logic [20:0] ld_codes);
        int         c;
        int         s;
        logic [2:0] e_dig;
        logic [6:0] e_seg;
        load   = ld;
        hundIn = ld_codes[20:14];
        tenIn  = ld_codes[13:7];
        oneIn  = ld_codes[6:0];
        @(posedge clk);
        #1;
        load = 1'b0;
        c = j % c_DWELL;
        s = j / c_DWELL;
        if (c < c_DEAD) begin
            e_dig = 3'b111;
            e_seg = c_B;
        end else if (s == 0) begin
            e_dig = 3'b011;
            e_seg = exp_codes[20:14];
        end else if (s == 1) begin
            e_dig = 3'b101;
            e_seg = exp_codes[13:7];
        end else begin
            e_dig = 3'b110;
            e_seg = exp_codes[6:0];
        end
        chk($sformatf("digitEn j=%0d", j), 32'(digitEn), 32'(e_dig));
        chk($sformatf("segOut j=%0d", j), 32'(segOut), 32'(e_seg));
        chk($sformatf("frameDone j=%0d", j), 32'(frameDone), 32'(j == c_FRAME - 1));
    endtask

    // A full frame with up to two loads at positions at1/at2 (-1 = none).
    task automatic run_frame(input logic [20:0] exp_codes,
                             input int at1, input logic [20:0] c1,
                             input int at2, input logic [20:0] c2);
        for (int j = 0; j < c_FRAME; j++) begin
            if (j == at1)      step(j, exp_codes, 1'b1, c1);
            else if (j == at2) step(j, exp_codes, 1'b1, c2);
            else               step(j, exp_codes, 1'b0, 21'h0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " segOut"},    32'(segOut),    32'h7F);
        chk({tag, " digitEn"},   32'(digitEn),   32'h7);
        chk({tag, " frameDone"}, 32'(frameDone), 32'h0);
    endtask

    localparam logic [20:0] c_ALL_B = {c_B, c_B, c_B};
    localparam logic [20:0] c_A     = {7'b1001111, 7'b0010010, 7'b0000110};
    localparam logic [20:0] c_009   = {7'b0000001, 7'b0000001, 7'b0000100};
    localparam logic [20:0] c_009BL = {c_B, c_B, 7'b0000100};
    localparam logic [20:0] c_050   = {7'b0000001, 7'b0100100, 7'b0000001};
    localparam logic [20:0] c_050BL = {c_B, 7'b0100100, 7'b0000001};
    localparam logic [20:0] c_X     = {7'h12, 7'h34, 7'h56};
    localparam logic [20:0] c_Y     = {7'h2A, 7'h15, 7'h33};
    localparam logic [20:0] c_Z     = {7'h0F, 7'h70, 7'h3C};
    localparam logic [20:0] c_C     = {7'h4F, 7'h66, 7'h6D};
    localparam logic [20:0] c_D     = {7'h11, 7'h22, 7'h44};

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        hundIn  = 7'h0;
        tenIn   = 7'h0;
        oneIn   = 7'h0;
        blankEn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // Idle frame: only timing, everything blank, frameDone at the end.
        run_frame(c_ALL_B, -1, 21'h0, -1, 21'h0);
        // Load mid-frame: current frame stays blank, next frame shows A.
        run_frame(c_ALL_B, 5, c_A, -1, 21'h0);
        run_frame(c_A, 3, c_009, -1, 21'h0);
        // Leading-zero blanking on 009, then the same codes unblanked.
        blankEn = 1'b1;
        run_frame(c_009BL, -1, 21'h0, -1, 21'h0);
        blankEn = 1'b0;
        run_frame(c_009, 4, c_050, -1, 21'h0);
        // 050: only hundreds blanked. Two loads in one frame, last one wins.
        blankEn = 1'b1;
        run_frame(c_050BL, 3, c_X, 10, c_Y);
        blankEn = 1'b0;
        // Pending Z overridden by C loaded on the boundary cycle itself.
        run_frame(c_Y, 5, c_Z, c_FRAME - 1, c_C);
        run_frame(c_C, -1, 21'h0, -1, 21'h0);
        // C must persist: stale pending Z must not resurface.
        for (int j = 0; j < 18; j++) begin
            if (j == 5) step(j, c_C, 1'b1, c_D);
            else        step(j, c_C, 1'b0, 21'h0);
        end
        // Reset during the ones slot discards both pending D and display C.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        reset = 1'b0;
        run_frame(c_ALL_B, -1, 21'h0, -1, 21'h0);
        run_frame(c_ALL_B, -1, 21'h0, -1, 21'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
